// File: rtl/alu_arb_pkg.sv
// alu_arb shared types: R-type funct codes and FSM state.
// Round-robin arbitration is enabled by defining ALU_ARB_RR_EN.
package alu_arb_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;

  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd33;
  localparam logic [5:0] F_ADDU = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLL  = 6'd38;
  localparam logic [5:0] F_SRL  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd40;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic        id;
  } op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational R-type decode and compute.
// Unsupported opcode/funct yields zero data with err set.
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [5:0] w_op;
  logic [4:0] w_sh;
  logic [5:0] w_fn;
  logic       w_unused;

  assign w_op = i_inst[31:26];
  assign w_sh = i_inst[10:6];
  assign w_fn = i_inst[5:0];
  assign w_unused = &{1'b0, i_inst[25:11]};

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    if (w_op != OP_RTYPE) begin
      o_err = 1'b1;
    end else begin
      case (w_fn)
        F_ADD, F_ADDU: o_data = i_a + i_b;
        F_SUB, F_SUBU: o_data = i_a - i_b;
        F_AND:         o_data = i_a & i_b;
        F_OR:          o_data = i_a | i_b;
        F_SLL:         o_data = i_a << w_sh;
        F_SRL:         o_data = i_a >> w_sh;
        F_SLT:         o_data = {31'd0, (i_a < i_b)};
        default:       o_err  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester ALU arbiter, one operation in flight.
// ALU_ARB_RR_EN selects round-robin; default is fixed req0 priority.
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_inst,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_inst,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  state_t      r_state;
  state_t      w_next;
  op_t         r_op;
  logic [31:0] r_data;
  logic        r_id;
  logic        r_err;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_idle;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_acc;
  logic [31:0] w_core_data;
  logic        w_core_err;

`ifdef ALU_ARB_RR_EN
  logic r_last;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b11: begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end
      2'b01:   w_gnt0 = 1'b1;
      2'b10:   w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_acc1;
    end
  end
`else
  assign w_gnt0 = req0_valid;
  assign w_gnt1 = req1_valid & ~req0_valid;
`endif

  // Ready is gated by rst_n so it drops the instant reset asserts.
  assign w_idle     = (r_state == S_IDLE) & rst_n;
  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_acc      = w_acc0 | w_acc1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == S_RESP);
    rsp_id    = r_id;
    rsp_data  = r_data;
    rsp_err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
    end else if (w_acc) begin
      if (w_acc1) begin
        r_op <= '{inst: req1_inst, a: req1_a,
                  b: req1_b, id: 1'b1};
      end else begin
        r_op <= '{inst: req0_inst, a: req0_a,
                  b: req0_b, id: 1'b0};
      end
    end
  end

  alu_core u_core (
    .i_inst (r_op.inst),
    .i_a    (r_op.a),
    .i_b    (r_op.b),
    .o_data (w_core_data),
    .o_err  (w_core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_id   <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_data <= w_core_data;
      r_id   <= r_op.id;
      r_err  <= w_core_err;
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: driver pushes expected responses,
// a negedge monitor pops and compares on each rsp handshake.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_inst = '0;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_inst = '0;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_inst  (req0_inst),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_inst  (req1_inst),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   m_last = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int sh,
                                     input int fn);
    logic [31:0] r;
    r = 32'(((op & 63) << 26) | ((sh & 31) << 6) | (fn & 63));
    return r;
  endfunction

  // Reference: the architectural meaning of each funct code.
  function automatic exp_t model(input logic id, input logic [31:0] inst,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int   sh;
    sh = int'(inst[10:6]);
    r.id = id;
    r.data = 32'd0;
    r.err = 1'b0;
    if (inst[31:26] != 6'd0) begin
      r.err = 1'b1;
    end else begin
      case (int'(inst[5:0]))
        32, 34:  r.data = a + b;
        33, 35:  r.data = a - b;
        36:      r.data = a & b;
        37:      r.data = a | b;
        38:      r.data = a << sh;
        39:      r.data = a >> sh;
        40:      r.data = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got data %h want no response",
                   rsp_data);
        end else begin
          m_e = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
          chk("rsp_data", rsp_data, m_e.data);
          chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
        end
      end
    end
  end

  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] i0, input logic [31:0] a0,
                     input logic [31:0] b0, input logic [31:0] i1,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input int hold, input bit rst_mid);
    bit   g;
    bit   got;
    int   lat;
    exp_t e;
    req0_valid = v0; req0_inst = i0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_inst = i1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_RR_EN
    g = (v0 && v1) ? ~m_last : !v0;
`else
    g = !v0;
`endif
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no ready want ready in 10 cycles");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    chk("accept_latency", 32'(lat), 32'd0);
    chk("req0_ready_gnt", 32'(req0_ready), 32'(!g));
    chk("req1_ready_gnt", 32'(req1_ready), 32'(g));
    e = g ? model(1'b1, i1, a1, b1) : model(1'b0, i0, a0, b0);
    sb_q.push_back(e);
    m_last = g;
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_inst = 32'($urandom);
    req1_inst = 32'($urandom);
    if (hold == 0 && !rst_mid) rsp_ready = 1'b1;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("hold_data", rsp_data, e.data);
      chk("hold_id", 32'(rsp_id), 32'(e.id));
      chk("hold_err", 32'(rsp_err), 32'(e.err));
      @(negedge clk);
    end
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      void'(sb_q.pop_back());
      m_last = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
    end else begin
      if (hold > 0) begin
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    int r;
    int op;
    int fn;
    r = int'($urandom_range(0, 15));
    op = (r == 0) ? int'($urandom_range(1, 63)) : 0;
    fn = (r == 1) ? int'($urandom_range(0, 63))
                  : int'($urandom_range(32, 40));
    return mk(op, int'($urandom_range(0, 31)), fn) |
           ({6'd0, 15'($urandom), 11'd0});
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish by 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add_i;
    logic [1:0]  v;
    add_i = mk(0, 0, 32);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      txn(1, 1, add_i, 32'(k), 32'd100, add_i, 32'(k), 32'd200, 0, 0);
    end

    txn(1, 0, add_i, 32'd5, 32'd7, '0, '0, '0, 0, 0);
    txn(0, 1, '0, '0, '0, mk(0, 0, 33), 32'd0, 32'd1, 0, 0);
    txn(0, 1, '0, '0, '0, mk(0, 0, 40), 32'hFFFF_FFFF, 32'd1, 1, 0);
    txn(1, 0, mk(0, 31, 38), 32'd1, 32'd0, '0, '0, '0, 2, 0);
    txn(1, 0, mk(0, 31, 39), 32'h8000_0000, 32'd0, '0, '0, '0, 0, 0);
    txn(1, 0, mk(2, 0, 32), 32'd3, 32'd4, '0, '0, '0, 0, 0);
    txn(0, 1, '0, '0, '0, mk(0, 0, 41), 32'd3, 32'd4, 0, 0);
    txn(1, 0, mk(0, 0, 36), 32'hF0F0_1234, 32'h0FF0_FFFF,
        '0, '0, '0, 5, 0);
    txn(0, 1, '0, '0, '0, mk(0, 0, 37), 32'h1200_0000, 32'h0000_0034,
        2, 1);
    txn(1, 1, add_i, 32'd9, 32'd9, add_i, 32'd1, 32'd1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      v = 2'($urandom_range(1, 3));
      txn(v[0], v[1], rnd_inst(), rnd_val(), rnd_val(),
          rnd_inst(), rnd_val(), rnd_val(),
          int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-004 SHALL have ports: reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-005 SHALL have ports: reqN_inst  input  32  R-type instruction word: opcode [31:26], shamt [10:6], funct [5:0].
REQ-006 SHALL have ports: reqN_a, reqN_b  input  32  operands A and B.
REQ-007 SHALL have port: rsp_valid  output  1  result available.
REQ-008 SHALL have port: rsp_ready  input  1  consumer takes result.
REQ-009 SHALL have port: rsp_id  output  1  requester index owning the result.
REQ-010 SHALL have port: rsp_data  output  32  ALU result.
REQ-011 SHALL have port: rsp_err  output  1  unsupported opcode/funct.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-013 In IDLE, reqN_ready SHALL be 1 only for the granted requester with reqN_valid=1; it SHALL be 0 in EXEC and RESP.
REQ-014 On accept (valid&ready at edge k), SHALL latch inst, a, b and id, then enter EXEC.
REQ-015 In EXEC, SHALL register the ALU result, rsp_id and rsp_err at edge k+1, enter RESP, and assert rsp_valid from k+1.
REQ-016 In RESP, SHALL hold rsp_* stable until rsp_valid&rsp_ready, then return to IDLE; the next accept is earliest at the following edge.
REQ-017 Funct decode when opcode=0:
- 32/34 add; 33/35 sub (32-bit wrap, no overflow flag)
- 36 and; 37 or
- 38 A<<shamt; 39 A>>shamt (logical)
- 40 unsigned A<B ? 1 : 0
REQ-018 Opcode!=0 or any other funct SHALL give rsp_data=0 and rsp_err=1, still delivered as a normal response.
REQ-019 Arbitration SHALL occur only in IDLE; a requester dropping valid before accept SHALL have no effect.
REQ-020 With only one requester valid, that requester SHALL be granted.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, reqN_ready=0, and last_grant=1.
REQ-022 Reset during EXEC or RESP SHALL drop the in-flight operation with no response.

Configuration
REQ-023 With ALU_ARB_RR_EN defined, when both requesters are valid the requester other than last_grant SHALL be granted; last_grant SHALL update on each accept.
REQ-024 Without ALU_ARB_RR_EN, req0 SHALL always win when both are valid; last_grant is absent.

Structure
REQ-025 Package alu_arb_pkg SHALL hold the funct constants (ADD=32 through SLT=40), OP_RTYPE=0, and the FSM state enum.
REQ-026 Sub-module alu_core SHALL contain the purely combinational decode/compute (inst, a, b -> data, err); alu_arb SHALL contain the FSM, arbitration and registers.

Verification
REQ-027 req0 add, a=5, b=7, rsp_ready=1 -> rsp_valid one edge after accept, rsp_data=12, rsp_id=0, rsp_err=0.
REQ-028 Both valid from reset, RR build -> grants in order 0,1,0,1; non-RR build -> four consecutive grants to 0.
REQ-029 req1 sub, a=0, b=1 -> rsp_data=0xFFFFFFFF; slt, a=0xFFFFFFFF, b=1 -> rsp_data=0 (unsigned compare).
REQ-030 sll, a=1, shamt=31 -> 0x80000000; srl, a=0x80000000, shamt=31 -> 1.
REQ-031 opcode=2 or funct=41 -> rsp_err=1, rsp_data=0.
REQ-032 rsp_ready held 0 for 5 cycles -> rsp_* stable and both reqN_ready=0; rst_n pulsed in RESP -> rsp_valid=0 immediately, FSM in IDLE.
